// File: rtl/gcm_len_counter_if.sv
// Chunk/length handshake bundle for gcm_len_counter: the producer drives chunks
// and finish, the counter returns the final bit lengths and sticky error flags.
interface gcm_len_counter_if;
  logic        start;
  logic        aad_valid;
  logic [4:0]  aad_bytes;
  logic        ct_valid;
  logic [4:0]  ct_bytes;
  logic        finish;
  logic        len_ready;
  logic        len_valid;
  logic [63:0] len_aad_bits;
  logic [63:0] len_ct_bits;
  logic        err_aad_ovf;
  logic        err_ct_ovf;
  logic        err_order;
  logic        err_bytes;

  modport master (
    output start, aad_valid, aad_bytes, ct_valid, ct_bytes, finish, len_ready,
    input  len_valid, len_aad_bits, len_ct_bits,
           err_aad_ovf, err_ct_ovf, err_order, err_bytes
  );

  modport slave (
    input  start, aad_valid, aad_bytes, ct_valid, ct_bytes, finish, len_ready,
    output len_valid, len_aad_bits, len_ct_bits,
           err_aad_ovf, err_ct_ovf, err_order, err_bytes
  );
endinterface

// File: rtl/gcm_len_counter.sv
// GCM length accumulator: sums AAD and CT chunk byte counts for one message and
// presents len(A)/len(C) in bits, with sticky error flags for illegal traffic.
module gcm_len_counter #(
  parameter logic [63:0] CT_MAX_BYTES  = 64'd68719476704,
  parameter logic [63:0] AAD_MAX_BYTES = 64'd2305843009213693951
) (
  input logic              clk,
  input logic              rst_n,
  gcm_len_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AAD  = 2'd1,
    S_CT   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [60:0] aad_cnt_q;
  logic [35:0] ct_cnt_q;
  logic        len_valid_q;
  logic        err_aad_ovf_q;
  logic        err_ct_ovf_q;
  logic        err_order_q;
  logic        err_bytes_q;

  logic [63:0] aad_sum;
  logic [63:0] ct_sum;
  logic        aad_bad;
  logic        ct_bad;
  logic        aad_ovf;
  logic        ct_ovf;

  // Sums are formed 64 bits wide so the limit compare cannot wrap.
  assign aad_sum = {3'd0, aad_cnt_q} + {59'd0, bus.aad_bytes};
  assign ct_sum  = {28'd0, ct_cnt_q} + {59'd0, bus.ct_bytes};
  assign aad_bad = (bus.aad_bytes == 5'd0) || (bus.aad_bytes > 5'd16);
  assign ct_bad  = (bus.ct_bytes == 5'd0) || (bus.ct_bytes > 5'd16);
  assign aad_ovf = aad_sum > AAD_MAX_BYTES;
  assign ct_ovf  = ct_sum > CT_MAX_BYTES;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      aad_cnt_q     <= '0;
      ct_cnt_q      <= '0;
      len_valid_q   <= 1'b0;
      err_aad_ovf_q <= 1'b0;
      err_ct_ovf_q  <= 1'b0;
      err_order_q   <= 1'b0;
      err_bytes_q   <= 1'b0;
    end else if (bus.start) begin
      state_q       <= S_AAD;
      aad_cnt_q     <= '0;
      ct_cnt_q      <= '0;
      len_valid_q   <= 1'b0;
      err_aad_ovf_q <= 1'b0;
      err_ct_ovf_q  <= 1'b0;
      err_order_q   <= 1'b0;
      err_bytes_q   <= 1'b0;
    end else begin
      case (state_q)
        S_AAD, S_CT: begin
          // AAD after the first CT chunk is an ordering violation and is dropped.
          if (bus.aad_valid) begin
            if (state_q == S_CT) err_order_q <= 1'b1;
            else if (aad_bad)    err_bytes_q <= 1'b1;
            else if (aad_ovf)    err_aad_ovf_q <= 1'b1;
            else                 aad_cnt_q <= aad_sum[60:0];
          end
          if (bus.ct_valid) begin
            if (ct_bad)      err_bytes_q <= 1'b1;
            else if (ct_ovf) err_ct_ovf_q <= 1'b1;
            else             ct_cnt_q <= ct_sum[35:0];
          end
          if (bus.finish) begin
            state_q     <= S_DONE;
            len_valid_q <= 1'b1;
          end else if (bus.ct_valid) begin
            state_q <= S_CT;
          end
        end
        S_DONE: begin
          if (bus.len_ready) begin
            state_q     <= S_IDLE;
            len_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.len_valid    = len_valid_q;
  assign bus.len_aad_bits = {aad_cnt_q, 3'd0};
  assign bus.len_ct_bits  = {25'd0, ct_cnt_q, 3'd0};
  assign bus.err_aad_ovf  = err_aad_ovf_q;
  assign bus.err_ct_ovf   = err_ct_ovf_q;
  assign bus.err_order    = err_order_q;
  assign bus.err_bytes    = err_bytes_q;

endmodule

// File: tb/tb_gcm_len_counter.sv
// Bench for gcm_len_counter: a default-limit instance (A) and a tiny-limit
// instance (B) share stimulus and are compared against a message-level model.
module tb_gcm_len_counter;

  localparam longint unsigned B_CT_MAX  = 48;
  localparam longint unsigned B_AAD_MAX = 40;
  localparam longint unsigned A_CT_MAX  = 64'd68719476704;
  localparam longint unsigned A_AAD_MAX = 64'd2305843009213693951;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  gcm_len_counter_if ifa ();
  gcm_len_counter_if ifb ();

  gcm_len_counter dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  gcm_len_counter #(
    .CT_MAX_BYTES  (64'd48),
    .AAD_MAX_BYTES (64'd40)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  typedef struct packed {
    logic       start;
    logic       av;
    logic [4:0] ab;
    logic       cv;
    logic [4:0] cb;
    logic       fin;
    logic       rdy;
  } stim_t;

  // Message-level view: phase 0 idle, 1 collecting AAD, 2 collecting CT, 3 lengths held.
  typedef struct {
    int              phase;
    longint unsigned aad;
    longint unsigned ct;
    bit              e_aov;
    bit              e_cov;
    bit              e_ord;
    bit              e_by;
  } m_t;

  typedef struct {
    stim_t       s;
    logic        lv;
    logic [63:0] a_aad;
    logic [63:0] a_ct;
    logic [3:0]  a_err;
    logic [63:0] b_aad;
    logic [63:0] b_ct;
    logic [3:0]  b_err;
  } vec_t;

  int checks = 0;
  int failures = 0;
  m_t ma;
  m_t mb;
  vec_t vt[$];

  function automatic m_t mreset();
    m_t n;
    n.phase = 0; n.aad = 0; n.ct = 0;
    n.e_aov = 0; n.e_cov = 0; n.e_ord = 0; n.e_by = 0;
    return n;
  endfunction

  function automatic m_t mnext(m_t m, stim_t s, longint unsigned ctmax, longint unsigned aadmax);
    m_t n = m;
    if (s.start) begin
      n = mreset();
      n.phase = 1;
      return n;
    end
    if (m.phase == 1 || m.phase == 2) begin
      if (s.av) begin
        if (m.phase == 2)                 n.e_ord = 1;
        else if (s.ab == 0 || s.ab > 16)  n.e_by = 1;
        else if (m.aad + s.ab > aadmax)   n.e_aov = 1;
        else                              n.aad = m.aad + s.ab;
      end
      if (s.cv) begin
        if (s.cb == 0 || s.cb > 16)       n.e_by = 1;
        else if (m.ct + s.cb > ctmax)     n.e_cov = 1;
        else                              n.ct = m.ct + s.cb;
        n.phase = 2;
      end
      if (s.fin) n.phase = 3;
    end else if (m.phase == 3 && s.rdy) begin
      n.phase = 0;
    end
    return n;
  endfunction

  function automatic stim_t mk(bit start, bit av, int ab, bit cv, int cb, bit fin, bit rdy);
    stim_t s;
    s.start = start; s.av = av; s.ab = 5'(ab); s.cv = cv; s.cb = 5'(cb);
    s.fin = fin; s.rdy = rdy;
    return s;
  endfunction

  task automatic addv(stim_t s, bit lv, logic [63:0] aa, logic [63:0] ac, logic [3:0] ae,
                      logic [63:0] ba, logic [63:0] bc, logic [3:0] be);
    vec_t v;
    v.s = s; v.lv = lv; v.a_aad = aa; v.a_ct = ac; v.a_err = ae;
    v.b_aad = ba; v.b_ct = bc; v.b_err = be;
    vt.push_back(v);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] errs_a();
    return {ifa.err_aad_ovf, ifa.err_ct_ovf, ifa.err_order, ifa.err_bytes};
  endfunction

  function automatic logic [3:0] errs_b();
    return {ifb.err_aad_ovf, ifb.err_ct_ovf, ifb.err_order, ifb.err_bytes};
  endfunction

  task automatic cmp_model();
    chk("A.len_valid", 64'(ifa.len_valid), 64'(ma.phase == 3));
    chk("A.aad_bits", ifa.len_aad_bits, ma.aad * 8);
    chk("A.ct_bits", ifa.len_ct_bits, ma.ct * 8);
    chk("A.errs", 64'(errs_a()), 64'({ma.e_aov, ma.e_cov, ma.e_ord, ma.e_by}));
    chk("B.len_valid", 64'(ifb.len_valid), 64'(mb.phase == 3));
    chk("B.aad_bits", ifb.len_aad_bits, mb.aad * 8);
    chk("B.ct_bits", ifb.len_ct_bits, mb.ct * 8);
    chk("B.errs", 64'(errs_b()), 64'({mb.e_aov, mb.e_cov, mb.e_ord, mb.e_by}));
  endtask

  task automatic apply(stim_t s);
    ifa.start = s.start; ifa.aad_valid = s.av; ifa.aad_bytes = s.ab;
    ifa.ct_valid = s.cv; ifa.ct_bytes = s.cb; ifa.finish = s.fin; ifa.len_ready = s.rdy;
    ifb.start = s.start; ifb.aad_valid = s.av; ifb.aad_bytes = s.ab;
    ifb.ct_valid = s.cv; ifb.ct_bytes = s.cb; ifb.finish = s.fin; ifb.len_ready = s.rdy;
  endtask

  task automatic cycle(stim_t s);
    apply(s);
    @(posedge clk);
    if (rst_n) begin
      ma = mnext(ma, s, A_CT_MAX, A_AAD_MAX);
      mb = mnext(mb, s, B_CT_MAX, B_AAD_MAX);
    end else begin
      ma = mreset();
      mb = mreset();
    end
    #1;
    cmp_model();
    $display("cyc t=%0t st=%0b av=%0b ab=%0d cv=%0b cb=%0d fin=%0b rdy=%0b | lv=%0b aad=%0d ct=%0d",
             $time, s.start, s.av, s.ab, s.cv, s.cb, s.fin, s.rdy,
             ifa.len_valid, ifa.len_aad_bits, ifa.len_ct_bits);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".A.len_valid"}, 64'(ifa.len_valid), 64'd0);
    chk({tag, ".A.aad_bits"}, ifa.len_aad_bits, 64'd0);
    chk({tag, ".A.ct_bits"}, ifa.len_ct_bits, 64'd0);
    chk({tag, ".A.errs"}, 64'(errs_a()), 64'd0);
    chk({tag, ".B.errs"}, 64'(errs_b()), 64'd0);
  endtask

  initial begin
    stim_t idle;
    stim_t s;
    idle = mk(0, 0, 0, 0, 0, 0, 0);
    ma = mreset();
    mb = mreset();
    apply(idle);

    // Reset state
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // Directed table: {stimulus, lv, A aad/ct bits, A errs, B aad/ct bits, B errs}; errs = {aov,cov,ord,by}
    addv(mk(1,0,0,0,0,0,0), 0,   0,   0, 4'b0000,   0,   0, 4'b0000);
    addv(mk(0,1,16,0,0,0,0),0, 128,   0, 4'b0000, 128,   0, 4'b0000);
    addv(mk(0,1,4,0,0,0,0), 0, 160,   0, 4'b0000, 160,   0, 4'b0000);
    addv(mk(0,0,0,1,16,0,0),0, 160, 128, 4'b0000, 160, 128, 4'b0000);
    addv(mk(0,0,0,1,16,0,0),0, 160, 256, 4'b0000, 160, 256, 4'b0000);
    addv(mk(0,0,0,1,16,0,0),0, 160, 384, 4'b0000, 160, 384, 4'b0000);
    addv(mk(0,0,0,1,12,0,0),0, 160, 480, 4'b0000, 160, 384, 4'b0100);
    addv(mk(0,0,0,0,0,1,0), 1, 160, 480, 4'b0000, 160, 384, 4'b0100);
    addv(mk(0,0,0,0,0,0,0), 1, 160, 480, 4'b0000, 160, 384, 4'b0100);
    addv(mk(0,0,0,0,0,0,1), 0, 160, 480, 4'b0000, 160, 384, 4'b0100);
    addv(mk(1,0,0,0,0,0,0), 0,   0,   0, 4'b0000,   0,   0, 4'b0000);
    addv(mk(0,0,0,0,0,1,0), 1,   0,   0, 4'b0000,   0,   0, 4'b0000);
    addv(mk(0,0,0,0,0,0,1), 0,   0,   0, 4'b0000,   0,   0, 4'b0000);
    addv(mk(0,1,16,1,16,1,0),0,  0,   0, 4'b0000,   0,   0, 4'b0000);
    addv(mk(1,0,0,0,0,0,0), 0,   0,   0, 4'b0000,   0,   0, 4'b0000);
    addv(mk(0,1,16,0,0,0,0),0, 128,   0, 4'b0000, 128,   0, 4'b0000);
    addv(mk(0,0,0,1,16,0,0),0, 128, 128, 4'b0000, 128, 128, 4'b0000);
    addv(mk(0,1,8,0,0,0,0), 0, 128, 128, 4'b0010, 128, 128, 4'b0010);
    addv(mk(0,0,0,0,0,1,0), 1, 128, 128, 4'b0010, 128, 128, 4'b0010);
    addv(mk(1,0,0,0,0,0,0), 0,   0,   0, 4'b0000,   0,   0, 4'b0000);
    addv(mk(0,1,0,0,0,0,0), 0,   0,   0, 4'b0001,   0,   0, 4'b0001);
    addv(mk(0,1,17,0,0,0,0),0,   0,   0, 4'b0001,   0,   0, 4'b0001);
    addv(mk(0,1,16,1,16,0,0),0,128, 128, 4'b0001, 128, 128, 4'b0001);
    addv(mk(0,0,0,1,8,1,0), 1, 128, 192, 4'b0001, 128, 192, 4'b0001);
    addv(mk(0,1,16,1,4,0,0),1, 128, 192, 4'b0001, 128, 192, 4'b0001);

    for (int i = 0; i < vt.size(); i++) begin
      cycle(vt[i].s);
      chk($sformatf("vec%0d.len_valid", i), 64'(ifa.len_valid), 64'(vt[i].lv));
      chk($sformatf("vec%0d.lv_b", i), 64'(ifb.len_valid), 64'(vt[i].lv));
      chk($sformatf("vec%0d.A.aad", i), ifa.len_aad_bits, vt[i].a_aad);
      chk($sformatf("vec%0d.A.ct", i), ifa.len_ct_bits, vt[i].a_ct);
      chk($sformatf("vec%0d.A.errs", i), 64'(errs_a()), 64'(vt[i].a_err));
      chk($sformatf("vec%0d.B.aad", i), ifb.len_aad_bits, vt[i].b_aad);
      chk($sformatf("vec%0d.B.ct", i), ifb.len_ct_bits, vt[i].b_ct);
      chk($sformatf("vec%0d.B.errs", i), 64'(errs_b()), 64'(vt[i].b_err));
    end

    // AAD limit on B: third 16-byte chunk exceeds 40 bytes
    cycle(mk(1,0,0,0,0,0,0));
    cycle(mk(0,1,16,0,0,0,0));
    cycle(mk(0,1,16,0,0,0,0));
    cycle(mk(0,1,16,0,0,0,0));
    chk("aadovf.B.aad", ifb.len_aad_bits, 64'd256);
    chk("aadovf.B.flag", 64'(ifb.err_aad_ovf), 64'd1);
    chk("aadovf.A.aad", ifa.len_aad_bits, 64'd384);

    // DONE held with len_ready low, then start from DONE
    cycle(mk(1,0,0,0,0,0,0));
    cycle(mk(0,1,8,0,0,0,0));
    cycle(mk(0,0,0,1,5,0,0));
    cycle(mk(0,0,0,0,0,1,0));
    for (int k = 0; k < 5; k++) begin
      cycle(mk(0, 1, 16, 1, 16, 1, 0));
      chk("hold.len_valid", 64'(ifa.len_valid), 64'd1);
      chk("hold.aad", ifa.len_aad_bits, 64'd64);
      chk("hold.ct", ifa.len_ct_bits, 64'd40);
    end
    cycle(mk(1,0,0,0,0,0,0));
    chk("restart.len_valid", 64'(ifa.len_valid), 64'd0);
    chk("restart.ct", ifa.len_ct_bits, 64'd0);
    cycle(mk(0,1,4,0,0,0,0));
    chk("restart.aad", ifa.len_aad_bits, 64'd32);

    // Asynchronous reset mid-CT, between clock edges
    cycle(mk(0,0,0,1,16,0,0));
    cycle(mk(0,0,0,1,16,0,0));
    chk("prereset.ct", ifa.len_ct_bits, 64'd256);
    apply(mk(0,0,0,1,16,0,0));
    #2 rst_n = 1'b0;
    #1;
    ma = mreset();
    mb = mreset();
    chk_zero("asyncrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(mk(0,0,0,1,16,0,0));
    cycle(mk(0,1,16,1,16,1,0));
    chk("postrst.ct", ifa.len_ct_bits, 64'd0);
    chk("postrst.len_valid", 64'(ifa.len_valid), 64'd0);
    cycle(mk(1,0,0,0,0,0,0));
    cycle(mk(0,0,0,1,16,0,0));
    chk("postrst.start_ct", ifa.len_ct_bits, 64'd128);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      s.start = ($urandom_range(0, 99) < 3);
      s.av    = ($urandom_range(0, 99) < 35);
      s.ab    = 5'($urandom_range(0, 17));
      s.cv    = ($urandom_range(0, 99) < 40);
      s.cb    = 5'($urandom_range(0, 17));
      s.fin   = ($urandom_range(0, 99) < 5);
      s.rdy   = ($urandom_range(0, 99) < 40);
      cycle(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
